ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch unit for the NPC core. Holds the architectural PC, issues one instruction-memory read per instruction over a valid/ready request/response handshake, and presents the fetched word and its PC to decode. After execute commits, it loads the PC from the next-PC generator output (`next_pc`) and starts the next fetch. The core is non-pipelined, so at most one instruction is in flight.

## Interface

Parameters:
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC value after reset.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset.
- `next_pc`, in, 64: next PC from the next-PC generator; bit 0 is already cleared.
- `pc_update`, in, 1: execute-commit pulse; load `next_pc`.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request.
- `imem_addr`, out, 64: fetch address, always equal to `pc`.
- `imem_resp_valid`, in, 1: response valid.
- `imem_resp_ready`, out, 1: fetch unit accepts the response.
- `imem_resp_data`, in, 32: instruction word.
- `imem_resp_err`, in, 1: access fault on this response.
- `inst_valid`, out, 1: instruction presented to decode.
- `inst_ready`, in, 1: decode consumes the instruction.
- `inst`, out, 32: instruction word.
- `inst_pc`, out, 64: PC of `inst`.
- `inst_err`, out, 2: 00 ok, 01 access fault, 10 misaligned PC.
- `fetch_cnt`, out, 64: number of committed PC updates.

## Operation

- States: IDLE, REQ, WAIT, HOLD, EXEC. Reset state is IDLE.
- IDLE: all handshake outputs are 0. Move to REQ on the first clock edge after `rst` deasserts.
- REQ: `imem_req_valid`=1 and `imem_addr`=`pc`, held stable until the request fires (`imem_req_valid` & `imem_req_ready`). On fire, move to WAIT.
- WAIT: `imem_resp_ready`=1. On `imem_resp_valid`, latch the data into `inst`, set `inst_err` = {1'b0, `imem_resp_err`}, and move to HOLD. If the response has `imem_resp_err`=1, `inst` = `imem_resp_data` and the error flag is still presented.
- HOLD: `inst_valid`=1. `inst`, `inst_pc` and `inst_err` are stable until `inst_ready`. On `inst_valid` & `inst_ready`, move to EXEC.
- EXEC: wait for `pc_update`. On `pc_update`:
  - load `pc` <= `next_pc`;
  - increment `fetch_cnt` by 1, modulo 2^64 (wraps from all-ones to 0);
  - if `next_pc[1]`=1: skip the memory request, set `inst`=32'h0000_0013 (nop), `inst_err`=10, and go directly to HOLD;
  - otherwise go to REQ.
- `pc_update` is ignored in every state except EXEC. It does not alter `pc` or `fetch_cnt`.
- `inst_pc` always equals `pc`; `imem_addr` always equals `pc`.
- All outputs are driven from registers or decoded directly from the state register. There is no combinational path from any input to any output.

## Timing

- Reset values (held while `rst`=1): state=IDLE, `pc`=`RESET_PC`, `inst`=0, `inst_err`=0, `fetch_cnt`=0, and all valid/ready outputs 0.
- Reset asserted mid-operation returns the block to IDLE immediately. The instruction memory shares `rst`, so no stale response arrives after reset.
- The first `imem_req_valid` is seen 1 cycle after the edge that leaves IDLE.
- Best-case loop, with memory ready at once, a response 1 cycle after fire, and immediate `inst_ready` and `pc_update`: 4 cycles per instruction (REQ, WAIT, HOLD, EXEC).
- Each wait cycle from memory, decode or execute extends the current state by exactly 1 cycle and changes nothing else.
- A misaligned update presents `inst_valid` on the cycle after `pc_update`.
- A response is never accepted in the same cycle as the request fire. `imem_resp_ready`=0 outside WAIT.

## Test plan

- Reset release, ready-at-once memory returning 32'h0010_0093: `imem_addr`=0x8000_0000 in REQ; `inst_valid` with `inst`=0x0010_0093, `inst_pc`=0x8000_0000, `inst_err`=00 at cycle 3 after leaving IDLE.
- `pc_update` with `next_pc`=0x8000_0004 in EXEC: next request has `imem_addr`=0x8000_0004; `fetch_cnt`=1. Back-to-back run of 10 instructions takes exactly 40 cycles.
- `imem_req_ready` low for 3 cycles, then response delayed 2 cycles, then `inst_ready` low for 4 cycles: `imem_addr` and `inst` stay stable throughout; no duplicate request is issued.
- Response with `imem_resp_err`=1: `inst_err`=01. A `pc_update` pulse during HOLD is ignored (`pc` unchanged, `fetch_cnt` unchanged).
- `next_pc`=0x8000_0006 at commit: no memory request; `inst`=0x0000_0013, `inst_err`=10, `inst_pc`=0x8000_0006 on the next cycle.
- Assert `rst` during WAIT: outputs take reset values immediately; after release, fetch restarts at 0x8000_0000 with `fetch_cnt`=0.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch unit bus: next-PC/commit inputs, instruction-memory request/response, decode output.
// The master modport is the fetch unit; the slave modport is its environment.
interface ifu_fetch_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic [XLEN-1:0] next_pc;
    logic            pc_update;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic            imem_resp_ready;
    logic [ILEN-1:0] imem_resp_data;
    logic            imem_resp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic [1:0]      inst_err;
    logic [XLEN-1:0] fetch_cnt;

    modport master (
        input  next_pc, pc_update, imem_req_ready, imem_resp_valid,
               imem_resp_data, imem_resp_err, inst_ready,
        output imem_req_valid, imem_addr, imem_resp_ready, inst_valid,
               inst, inst_pc, inst_err, fetch_cnt
    );

    modport slave (
        output next_pc, pc_update, imem_req_ready, imem_resp_valid,
               imem_resp_data, imem_resp_err, inst_ready,
        input  imem_req_valid, imem_addr, imem_resp_ready, inst_valid,
               inst, inst_pc, inst_err, fetch_cnt
    );
endinterface

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: one memory read per instruction, held for decode,
// then waits for execute commit to load the next PC.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    ifu_fetch_if.master bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, EXEC} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [ILEN-1:0] inst_q, inst_nxt;
    logic [1:0]      err_q, err_nxt;
    logic [XLEN-1:0] cnt_q, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            inst_q <= '0;
            err_q  <= 2'b00;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            inst_q <= inst_nxt;
            err_q  <= err_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst_q;
        err_nxt   = err_q;
        cnt_nxt   = cnt_q;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (bus.imem_req_ready) state_nxt = WAIT;
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    inst_nxt  = bus.imem_resp_data;
                    err_nxt   = {1'b0, bus.imem_resp_err};
                    state_nxt = HOLD;
                end
            end
            HOLD: if (bus.inst_ready) state_nxt = EXEC;
            EXEC: begin
                if (bus.pc_update) begin
                    pc_nxt  = bus.next_pc;
                    cnt_nxt = cnt_q + XLEN'(1);
                    // A halfword-misaligned target never reaches memory; decode sees a faulting nop.
                    if (bus.next_pc[1]) begin
                        inst_nxt  = NOP;
                        err_nxt   = 2'b10;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    assign bus.imem_req_valid  = (state == REQ);
    assign bus.imem_resp_ready = (state == WAIT);
    assign bus.inst_valid      = (state == HOLD);
    assign bus.imem_addr       = pc;
    assign bus.inst_pc         = pc;
    assign bus.inst            = inst_q;
    assign bus.inst_err        = err_q;
    assign bus.fetch_cnt       = cnt_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized stalls, data and
// next-PC values, checked against a transaction-level model of PC, count and latency.
module tb_ifu_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [63:0] exp_pc   = RESET_PC;
    logic [63:0] exp_cnt  = '0;
    logic [31:0] exp_inst = '0;
    logic [1:0]  exp_err  = 2'b00;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    // Inputs that must have no effect outside their own state.
    task automatic noise();
        bus.pc_update = 1'($urandom_range(0, 1));
        bus.next_pc   = rand64();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"},  64'(bus.imem_req_valid), 64'd0);
        chk({tag, "_resp_ready"}, 64'(bus.imem_resp_ready), 64'd0);
        chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd0);
        chk({tag, "_inst"},       64'(bus.inst), 64'd0);
        chk({tag, "_inst_pc"},    bus.inst_pc, RESET_PC);
        chk({tag, "_addr"},       bus.imem_addr, RESET_PC);
        chk({tag, "_inst_err"},   64'(bus.inst_err), 64'd0);
        chk({tag, "_fetch_cnt"},  bus.fetch_cnt, 64'd0);
    endtask

    task automatic do_req(input int dly);
        for (int i = 0; i <= dly; i++) begin
            chk("req_valid",      64'(bus.imem_req_valid), 64'd1);
            chk("req_addr",       bus.imem_addr, exp_pc);
            chk("req_resp_ready", 64'(bus.imem_resp_ready), 64'd0);
            chk("req_inst_valid", 64'(bus.inst_valid), 64'd0);
            chk("req_fetch_cnt",  bus.fetch_cnt, exp_cnt);
            bus.imem_req_ready = (i == dly);
            noise();
            @(negedge clk);
        end
        bus.imem_req_ready = 1'b0;
        bus.pc_update      = 1'b0;
    endtask

    task automatic do_wait(input int dly, input logic [31:0] data, input logic err);
        for (int i = 0; i <= dly; i++) begin
            chk("wait_req_valid",  64'(bus.imem_req_valid), 64'd0);
            chk("wait_resp_ready", 64'(bus.imem_resp_ready), 64'd1);
            chk("wait_inst_valid", 64'(bus.inst_valid), 64'd0);
            chk("wait_addr",       bus.imem_addr, exp_pc);
            bus.imem_resp_valid = (i == dly);
            bus.imem_resp_data  = (i == dly) ? data : 32'($urandom);
            bus.imem_resp_err   = (i == dly) ? err : 1'($urandom_range(0, 1));
            noise();
            @(negedge clk);
        end
        bus.imem_resp_valid = 1'b0;
        bus.pc_update       = 1'b0;
        exp_inst = data;
        exp_err  = {1'b0, err};
    endtask

    task automatic do_hold(input int dly);
        for (int i = 0; i <= dly; i++) begin
            chk("hold_inst_valid", 64'(bus.inst_valid), 64'd1);
            chk("hold_inst",       64'(bus.inst), 64'(exp_inst));
            chk("hold_inst_pc",    bus.inst_pc, exp_pc);
            chk("hold_inst_err",   64'(bus.inst_err), 64'(exp_err));
            chk("hold_req_valid",  64'(bus.imem_req_valid), 64'd0);
            chk("hold_resp_ready", 64'(bus.imem_resp_ready), 64'd0);
            chk("hold_fetch_cnt",  bus.fetch_cnt, exp_cnt);
            bus.inst_ready = (i == dly);
            noise();
            if (i == 0 && dly > 0) bus.pc_update = 1'b1;
            @(negedge clk);
        end
        bus.inst_ready = 1'b0;
        bus.pc_update  = 1'b0;
    endtask

    task automatic do_exec(input int dly, input logic [63:0] npc, output bit mis);
        for (int i = 0; i <= dly; i++) begin
            chk("exec_inst_valid", 64'(bus.inst_valid), 64'd0);
            chk("exec_req_valid",  64'(bus.imem_req_valid), 64'd0);
            chk("exec_resp_ready", 64'(bus.imem_resp_ready), 64'd0);
            chk("exec_inst_pc",    bus.inst_pc, exp_pc);
            chk("exec_fetch_cnt",  bus.fetch_cnt, exp_cnt);
            bus.pc_update  = (i == dly);
            bus.next_pc    = (i == dly) ? npc : rand64();
            bus.inst_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.pc_update  = 1'b0;
        bus.inst_ready = 1'b0;
        exp_pc  = npc;
        exp_cnt = exp_cnt + 64'd1;
        mis     = npc[1];
        if (mis) begin
            exp_inst = NOP;
            exp_err  = 2'b10;
        end
    endtask

    initial begin
        bit          mis;
        bit          pending_hold;
        int          c0;
        int          rq, rs, dc, ex, expected_cycles;
        logic [63:0] npc;

        bus.next_pc         = '0;
        bus.pc_update       = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;

        // Reset values, then the IDLE cycle right after release.
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;
        c0  = cyc;
        chk_reset_outputs("idle");
        @(negedge clk);

        // First fetch: decode sees it on the third cycle after leaving IDLE.
        do_req(0);
        do_wait(0, 32'h0010_0093, 1'b0);
        chk("first_inst_latency", 64'(cyc - c0), 64'd3);
        do_hold(0);
        do_exec(0, 64'h8000_0004, mis);

        // Ten instructions back to back take 40 cycles (first one counted from its REQ).
        c0 = cyc - 4;
        for (int k = 0; k < 9; k++) begin
            do_req(0);
            do_wait(0, 32'($urandom), 1'b0);
            do_hold(0);
            do_exec(0, exp_pc + 64'd4, mis);
        end
        chk("ten_instr_cycles", 64'(cyc - c0), 64'd40);

        // Stalls on every side, faulting response, ignored pc_update in HOLD, then misaligned target.
        c0 = cyc;
        do_req(3);
        do_wait(2, 32'($urandom), 1'b1);
        do_hold(4);
        do_exec(0, 64'h8000_0006, mis);
        chk("stall_cycles", 64'(cyc - c0), 64'd13);
        c0 = cyc;
        do_hold(0);
        chk("mis_hold_cycles", 64'(cyc - c0), 64'd1);
        do_exec(1, 64'h8000_0100, mis);

        // Randomized traffic with a latency model of 4 cycles plus stalls per instruction.
        pending_hold = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rq = $urandom_range(0, 3);
            rs = $urandom_range(0, 3);
            dc = $urandom_range(0, 3);
            ex = $urandom_range(0, 3);
            npc = rand64() & ~64'd1;
            if ($urandom_range(0, 3) != 0) npc[1] = 1'b0;
            c0 = cyc;
            if (pending_hold) begin
                expected_cycles = 2 + dc + ex;
            end else begin
                expected_cycles = 4 + rq + rs + dc + ex;
                do_req(rq);
                do_wait(rs, 32'($urandom), 1'($urandom_range(0, 1)));
            end
            do_hold(dc);
            do_exec(ex, npc, mis);
            chk("rand_instr_cycles", 64'(cyc - c0), 64'(expected_cycles));
            pending_hold = mis;
        end
        if (pending_hold) begin
            do_hold(0);
            do_exec(0, 64'h8000_0200, mis);
        end

        // Reset in WAIT takes effect asynchronously; fetch restarts from RESET_PC.
        do_req(1);
        rst = 1'b1;
        #1;
        exp_pc   = RESET_PC;
        exp_cnt  = '0;
        exp_inst = '0;
        exp_err  = 2'b00;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("midrst_idle");
        @(negedge clk);
        do_req(0);
        do_wait(1, 32'hdead_beef, 1'b0);
        do_hold(0);
        do_exec(0, 64'h8000_0008, mis);
        chk("post_rst_fetch_cnt", bus.fetch_cnt, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
